// File: rtl/dkong_hs_if.sv
// Hiscore transfer port bundle: RAM side (hs_*), load/save byte streams,
// and the request/status lines of dkong_hs_engine. O_CSUM_ERR exists only
// when DKONG_HS_CHECKSUM_EN is defined.
interface dkong_hs_if;
  logic [15:0] O_HS_ADDRESS;
  logic [7:0]  O_HS_DATA_IN;
  logic        O_HS_WRITE;
  logic        O_HS_ACCESS;
  logic [7:0]  I_HS_DATA_OUT;
  logic        I_SAVE_REQ;
  logic        I_LOAD_REQ;
  logic        I_VBLANKn;
  logic [7:0]  I_LD_DATA;
  logic        I_LD_VALID;
  logic        O_LD_READY;
  logic [7:0]  O_SV_DATA;
  logic        O_SV_VALID;
  logic        I_SV_READY;
  logic        O_PAUSE;
  logic        O_BUSY;
  logic        O_DONE;
  logic [7:0]  O_CHECKSUM;
`ifdef DKONG_HS_CHECKSUM_EN
  logic        O_CSUM_ERR;
`endif

  modport master (
    output
`ifdef DKONG_HS_CHECKSUM_EN
    O_CSUM_ERR,
`endif
    O_HS_ADDRESS, O_HS_DATA_IN, O_HS_WRITE, O_HS_ACCESS, O_LD_READY,
    O_SV_DATA, O_SV_VALID, O_PAUSE, O_BUSY, O_DONE, O_CHECKSUM,
    input  I_HS_DATA_OUT, I_SAVE_REQ, I_LOAD_REQ, I_VBLANKn, I_LD_DATA,
    I_LD_VALID, I_SV_READY
  );

  modport slave (
    input
`ifdef DKONG_HS_CHECKSUM_EN
    O_CSUM_ERR,
`endif
    O_HS_ADDRESS, O_HS_DATA_IN, O_HS_WRITE, O_HS_ACCESS, O_LD_READY,
    O_SV_DATA, O_SV_VALID, O_PAUSE, O_BUSY, O_DONE, O_CHECKSUM,
    output I_HS_DATA_OUT, I_SAVE_REQ, I_LOAD_REQ, I_VBLANKn, I_LD_DATA,
    I_LD_VALID, I_SV_READY
  );
endinterface

// File: rtl/dkong_hs_engine.sv
// Hiscore transfer engine: copies LENGTH bytes at START_ADDR out to the
// save stream, or writes the load stream back into that region. Transfers
// start only in vblank and hold the CPU paused throughout.
// Optional feature macro: DKONG_HS_CHECKSUM_EN (trailing checksum byte).
module dkong_hs_engine #(
  parameter logic [15:0] START_ADDR = 16'h6100,
  parameter int          LENGTH     = 168
) (
  input logic        I_CLK_24576M,
  input logic        I_RESETn,
  dkong_hs_if.master hs
);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] WAIT_VBL  = 4'd1;
  localparam logic [3:0] RD_ADDR   = 4'd2;
  localparam logic [3:0] RD_WAIT   = 4'd3;
  localparam logic [3:0] RD_CAP    = 4'd4;
  localparam logic [3:0] RD_PUSH   = 4'd5;
  localparam logic [3:0] WR_FETCH  = 4'd6;
  localparam logic [3:0] WR_SETUP  = 4'd7;
  localparam logic [3:0] WR_STROBE = 4'd8;
`ifdef DKONG_HS_CHECKSUM_EN
  localparam logic [3:0] CS_XFER   = 4'd9;
`endif
  localparam logic [3:0] DONE      = 4'd10;

  localparam logic [9:0] LAST_IDX = 10'(LENGTH - 1);

  logic [3:0] state;
  logic       save_mode;
  logic [9:0] idx;
  logic [7:0] sv_data;
  logic [7:0] wr_data;
  logic [7:0] csum;
  logic       own;
`ifdef DKONG_HS_CHECKSUM_EN
  logic       csum_err;
  logic       cs_save;
  logic       cs_load;
`endif

  // Request capture, transfer sequencing, data/checksum registers
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state     <= IDLE;
      save_mode <= 1'b0;
      idx       <= '0;
      sv_data   <= '0;
      wr_data   <= '0;
      csum      <= '0;
`ifdef DKONG_HS_CHECKSUM_EN
      csum_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // save has priority when both pulse together
          if (hs.I_SAVE_REQ || hs.I_LOAD_REQ) begin
            save_mode <= hs.I_SAVE_REQ;
            state     <= WAIT_VBL;
`ifdef DKONG_HS_CHECKSUM_EN
            csum_err  <= 1'b0;
`endif
          end
        end
        WAIT_VBL: begin
          if (!hs.I_VBLANKn) begin
            idx   <= '0;
            csum  <= '0;
            state <= save_mode ? RD_ADDR : WR_FETCH;
          end
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: state <= RD_CAP;
        RD_CAP: begin
          sv_data <= hs.I_HS_DATA_OUT;
          csum    <= csum + hs.I_HS_DATA_OUT;
          state   <= RD_PUSH;
        end
        RD_PUSH: begin
          if (hs.I_SV_READY) begin
            if (idx == LAST_IDX) begin
`ifdef DKONG_HS_CHECKSUM_EN
              sv_data <= csum;
              state   <= CS_XFER;
`else
              state   <= DONE;
`endif
            end else begin
              idx   <= idx + 10'd1;
              state <= RD_ADDR;
            end
          end
        end
        WR_FETCH: begin
          if (hs.I_LD_VALID) begin
            wr_data <= hs.I_LD_DATA;
            csum    <= csum + hs.I_LD_DATA;
            state   <= WR_SETUP;
          end
        end
        WR_SETUP: state <= WR_STROBE;
        WR_STROBE: begin
          if (idx == LAST_IDX) begin
`ifdef DKONG_HS_CHECKSUM_EN
            state <= CS_XFER;
`else
            state <= DONE;
`endif
          end else begin
            idx   <= idx + 10'd1;
            state <= WR_FETCH;
          end
        end
`ifdef DKONG_HS_CHECKSUM_EN
        CS_XFER: begin
          // save emits the sum; load compares the trailing byte against it
          if (save_mode) begin
            if (hs.I_SV_READY) state <= DONE;
          end else if (hs.I_LD_VALID) begin
            csum_err <= (hs.I_LD_DATA != csum);
            state    <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port is owned (and the CPU paused) only while actually transferring
  assign own = (state != IDLE) && (state != WAIT_VBL) && (state != DONE);

`ifdef DKONG_HS_CHECKSUM_EN
  assign cs_save = (state == CS_XFER) && save_mode;
  assign cs_load = (state == CS_XFER) && !save_mode;
  assign hs.O_CSUM_ERR = csum_err;
  assign hs.O_SV_VALID = (state == RD_PUSH) || cs_save;
  assign hs.O_LD_READY = (state == WR_FETCH) || cs_load;
`else
  assign hs.O_SV_VALID = (state == RD_PUSH);
  assign hs.O_LD_READY = (state == WR_FETCH);
`endif

  // Address is forced to zero whenever the port is not owned
  assign hs.O_HS_ADDRESS = own ? (START_ADDR + {6'd0, idx}) : 16'h0000;
  assign hs.O_HS_DATA_IN = wr_data;
  assign hs.O_HS_WRITE   = (state == WR_STROBE);
  assign hs.O_HS_ACCESS  = own;
  assign hs.O_PAUSE      = own;
  assign hs.O_BUSY       = (state != IDLE);
  assign hs.O_DONE       = (state == DONE);
  assign hs.O_SV_DATA    = sv_data;
  assign hs.O_CHECKSUM   = csum;
endmodule
